// File: rtl/cmd_pkg.sv
// Shared types and field layout for the SPI command path between the command
// FIFO and the register-file dispatcher.
package cmd_pkg;

  localparam int unsigned ENTRY_W = 72;
  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned DATA_W  = 64;

  localparam int unsigned RD_BIT  = 71;
  localparam int unsigned ADDR_HI = 70;
  localparam int unsigned ADDR_LO = 64;
  localparam int unsigned DATA_HI = 63;
  localparam int unsigned DATA_LO = 0;

  typedef struct packed {
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ISSUE,
    ST_RSP_WAIT
  } cmd_state_e;

endpackage

// File: rtl/cmd_dispatch.sv
// Pops SPI command FIFO entries, decodes them into register reads/writes,
// issues them over valid/ready and captures read responses with a timeout.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int unsigned WIDTH       = 72,
  parameter int unsigned NUM_REGS    = 64,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  input  logic             fifo_rd_empty,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_is_read,
  output logic [6:0]       cmd_addr,
  output logic [63:0]      cmd_wdata,
  input  logic             rsp_valid,
  input  logic [63:0]      rsp_data,
  output logic [63:0]      rb_data,
  output logic             rb_valid,
  output logic             err_addr,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [15:0]      cmd_count,
  output logic             busy
);

  localparam int unsigned TMO_W = $clog2(RSP_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RSP_TIMEOUT - 1);

  cmd_state_e       state_q, state_d;
  cmd_entry_t       entry_q, entry_d;
  cmd_entry_t       fetched;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             fifo_rd_en_q, fifo_rd_en_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic [63:0]      rb_data_q, rb_data_d;
  logic             rb_valid_q, rb_valid_d;
  logic             err_addr_q, err_addr_d;
  logic             err_timeout_q, err_timeout_d;
  logic [15:0]      cmd_count_q, cmd_count_d;
  logic             busy_q, busy_d;

  always_comb begin
    fetched      = '0;
    fetched.rd   = fifo_rd_data[RD_BIT];
    fetched.addr = fifo_rd_data[ADDR_HI:ADDR_LO];
    fetched.data = fifo_rd_data[DATA_HI:DATA_LO];
  end

  always_comb begin
    state_d       = state_q;
    entry_d       = entry_q;
    tmo_d         = tmo_q;
    rb_data_d     = rb_data_q;
    rb_valid_d    = 1'b0;
    // Clear first so that an error event later in this block overrides it.
    err_addr_d    = err_clr ? 1'b0 : err_addr_q;
    err_timeout_d = err_clr ? 1'b0 : err_timeout_q;
    cmd_count_d   = cmd_count_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_rd_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        entry_d = fetched;
        if (32'(fetched.addr) >= NUM_REGS) begin
          err_addr_d  = 1'b1;
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          if (entry_q.rd) begin
            tmo_d   = '0;
            state_d = ST_RSP_WAIT;
          end else begin
            cmd_count_d = cmd_count_q + 16'd1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_RSP_WAIT: begin
        if (rsp_valid) begin
          rb_data_d   = rsp_data;
          rb_valid_d  = 1'b1;
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          cmd_count_d   = cmd_count_q + 16'd1;
          state_d       = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are derived from the next state so they line up with it as flops.
    fifo_rd_en_d = (state_d == ST_FETCH);
    cmd_valid_d  = (state_d == ST_ISSUE);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      entry_q       <= '0;
      tmo_q         <= '0;
      fifo_rd_en_q  <= 1'b0;
      cmd_valid_q   <= 1'b0;
      rb_data_q     <= '0;
      rb_valid_q    <= 1'b0;
      err_addr_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      cmd_count_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      tmo_q         <= tmo_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      cmd_valid_q   <= cmd_valid_d;
      rb_data_q     <= rb_data_d;
      rb_valid_q    <= rb_valid_d;
      err_addr_q    <= err_addr_d;
      err_timeout_q <= err_timeout_d;
      cmd_count_q   <= cmd_count_d;
      busy_q        <= busy_d;
    end
  end

  assign fifo_rd_en  = fifo_rd_en_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_is_read = entry_q.rd;
  assign cmd_addr    = entry_q.addr;
  assign cmd_wdata   = entry_q.data;
  assign rb_data     = rb_data_q;
  assign rb_valid    = rb_valid_q;
  assign err_addr    = err_addr_q;
  assign err_timeout = err_timeout_q;
  assign cmd_count   = cmd_count_q;
  assign busy        = busy_q;

endmodule
